// File: rtl/fetch_unit_pkg.sv
// Definitions: shared types and constant tables for the fetch unit.
//   fetch_state_t : run-control state encoding (IDLE, RUN, HALT)
//   JUMP_TARG     : absolute jump targets, indexed by TargSel
//   BR_OFFS       : signed 8-bit branch offsets, indexed by TargSel
package Definitions;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   // Targets are stored wider than any expected PC; the lookup keeps the low PC_W bits.
   localparam logic [15:0] JUMP_TARG [4] = '{16'd0, 16'd16, 16'd64, 16'd128};

   localparam logic signed [7:0] BR_OFFS [4] = '{-8'sd4, -8'sd8, 8'sd4, 8'sd8};

endpackage

// File: rtl/fetch_unit_targ.sv
// targ_lut: combinational lookup of jump target and branch offset.
//   targ_sel  : table index from the decoder (TargSel)
//   jump_targ : absolute jump address, PC_W bits
//   br_offs   : branch offset sign-extended to PC_W bits (two's complement)
module targ_lut
   import Definitions::*;
#(
   parameter int PC_W = 10
) (
   input  logic [1:0]      targ_sel,
   output logic [PC_W-1:0] jump_targ,
   output logic [PC_W-1:0] br_offs
);

   logic signed [7:0] offs;

   assign offs      = BR_OFFS[targ_sel];
   assign jump_targ = JUMP_TARG[targ_sel][PC_W-1:0];
   // Sign extension lets a plain modulo-2**PC_W add move the PC backwards.
   assign br_offs   = {{(PC_W-8){offs[7]}}, offs};

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and start/run/halt control for the datapath front end.
//   Clk, Reset_n : clock and asynchronous active-low reset
//   Start        : harness request to (re)start at address 0 from IDLE or HALT
//   Jump, BranchEn, TargSel, Ack : decoder flow controls for the current instruction
//   Zero         : ALU flag, takes a conditional branch when high
//   ProgCtr      : instruction ROM address
//   Running      : state is RUN
//   Done         : halted, held until the next Start
//   CycleCnt     : saturating count of RUN cycles since the last Start
module fetch_unit
   import Definitions::*;
#(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Jump,
   input  logic             BranchEn,
   input  logic [1:0]       TargSel,
   input  logic             Ack,
   input  logic             Zero,
   output logic [PC_W-1:0]  ProgCtr,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCnt
);

   fetch_state_t    state_q;
   fetch_state_t    state_d;
   logic [PC_W-1:0] jump_targ;
   logic [PC_W-1:0] br_offs;
   logic [PC_W-1:0] pc_next;
   logic            launch;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   targ_lut #(
      .PC_W (PC_W)
   ) u_targ_lut (
      .targ_sel  (TargSel),
      .jump_targ (jump_targ),
      .br_offs   (br_offs)
   );

   // Start only matters outside RUN; a held Start restarts once, then is ignored in RUN.
   assign launch = Start && (state_q != RUN);

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (Start) state_d = RUN;
         RUN:     if (Ack)   state_d = HALT;
         HALT:    if (Start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the registered state, so Running never glitches
   always_comb begin
      Running = (state_q == RUN);
   end

   // Next-PC mux for a RUN cycle; priority Ack > Jump > taken branch > step
   always_comb begin
      pc_next = ProgCtr + PC_W'(1);
      if (Ack) begin
         pc_next = ProgCtr;
      end else if (Jump) begin
         pc_next = jump_targ;
      end else if (BranchEn && Zero) begin
         pc_next = ProgCtr + br_offs;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ProgCtr  <= '0;
         CycleCnt <= '0;
         Done     <= 1'b0;
      end else if (launch) begin
         ProgCtr  <= '0;
         CycleCnt <= '0;
         Done     <= 1'b0;
      end else if (state_q == RUN) begin
         ProgCtr  <= pc_next;
         CycleCnt <= sat_inc(CycleCnt);
         if (Ack) begin
            Done <= 1'b1;
         end
      end
   end

endmodule
